// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  // Arbiter operating mode: zero-fill of the register file, then normal arbitration.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Round-robin pointer: which requester wins the next contested cycle.
  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  // Register 31 is the hard-wired zero register and is never written.
  localparam logic [4:0] XZR_IDX    = 5'd31;
  // Last register written by the zero-fill sequence.
  localparam logic [4:0] CLEAR_LAST = 5'd30;

  // True when a destination index refers to a real, writable register.
  function automatic logic is_writable(input logic [4:0] idx);
    return (idx != XZR_IDX);
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_dec5to32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when disabled.
module dec5to32 (
  input  logic        en,
  input  logic [4:0]  a,
  output logic [31:0] y
);

  // Drive the single row selected by a, only while enabled.
  always_comb begin
    y = 32'h0000_0000;
    if (en) begin
      y[a] = 1'b1;
    end else begin
      y = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Two-requester register-file write-port arbiter. After reset it zero-fills
// registers 0..30, then grants one write per cycle to A or B with a
// round-robin tie-break. The write port outputs are registered (1-cycle latency).
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [4:0]        a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [4:0]        b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   rf_we_onehot,
  output logic              busy
);

  state_e            state_q;
  logic [4:0]        cnt_q;
  rr_e               rr_q;
  logic              we_q;
  logic [4:0]        waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              a_grant_d;
  logic              b_grant_d;
  logic              contested_d;

  // Grant decision: a lone requester always wins, a tie goes to the RR pointer.
  always_comb begin
    a_grant_d   = 1'b0;
    b_grant_d   = 1'b0;
    contested_d = a_valid && b_valid;
    if (state_q == ST_RUN) begin
      a_grant_d = a_valid && (!b_valid || (rr_q == RR_A));
      b_grant_d = b_valid && (!a_valid || (rr_q == RR_B));
    end else begin
      a_grant_d = 1'b0;
      b_grant_d = 1'b0;
    end
  end

  assign a_ready = a_grant_d;
  assign b_ready = b_grant_d;
  assign busy    = (state_q == ST_CLEAR);

  // Mode FSM, zero-fill counter, RR pointer and the registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= 5'd0;
      rr_q    <= RR_A;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          we_q    <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= '0;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == CLEAR_LAST) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (a_grant_d) begin
            we_q    <= is_writable(a_addr);
            waddr_q <= a_addr;
            wdata_q <= a_data;
          end else if (b_grant_d) begin
            we_q    <= is_writable(b_addr);
            waddr_q <= b_addr;
            wdata_q <= b_data;
          end else begin
            we_q    <= 1'b0;
          end
          // Only a contested grant moves the pointer; lone grants leave it be.
          if (contested_d) begin
            rr_q <= (rr_q == RR_A) ? RR_B : RR_A;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= 5'd0;
          rr_q    <= RR_A;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  dec5to32 u_dec (
    .en (we_q),
    .a  (waddr_q),
    .y  (rf_we_onehot)
  );

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with a scoreboard of expected write-port values.
module tb_rf_wport_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic [4:0]    a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   rf_we_onehot;
  logic          busy;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DATA_W(DW), .NREG(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_we_onehot (rf_we_onehot),
    .busy         (busy)
  );

  typedef struct packed {
    logic          we;
    logic [4:0]    addr;
    logic [DW-1:0] data;
    logic [31:0]   oh;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit            m_clear;
  int            m_cnt;
  bit            m_rr;
  logic          m_we;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_ar, m_br;

  // readies observed in the most recent cycle
  logic          obs_ar, obs_br;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check readies mid-cycle, predict the next write-port state,
  // then compare it after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    m_ar = !m_clear && a_valid && (!b_valid || !m_rr);
    m_br = !m_clear && b_valid && (!a_valid || m_rr);
    obs_ar = a_ready;
    obs_br = b_ready;
    chk("a_ready", 64'(a_ready), 64'(m_ar));
    chk("b_ready", 64'(b_ready), 64'(m_br));
    chk("ready_excl", 64'(a_ready & b_ready), 64'(1'b0));
    chk("busy", 64'(busy), 64'(m_clear));
    if (reset) begin
      m_clear = 1'b1; m_cnt = 0; m_rr = 1'b0;
      m_we = 1'b0; m_waddr = 5'd0; m_wdata = '0;
    end else if (m_clear) begin
      m_we = 1'b1; m_waddr = 5'(m_cnt); m_wdata = '0;
      if (m_cnt == 30) m_clear = 1'b0;
      m_cnt++;
    end else begin
      if (m_ar) begin
        m_we = (a_addr != 5'd31); m_waddr = a_addr; m_wdata = a_data;
      end else if (m_br) begin
        m_we = (b_addr != 5'd31); m_waddr = b_addr; m_wdata = b_data;
      end else begin
        m_we = 1'b0;
      end
      if (a_valid && b_valid) m_rr = !m_rr;
    end
    e.we   = m_we;
    e.addr = m_waddr;
    e.data = m_wdata;
    e.oh   = m_we ? (32'h1 << m_waddr) : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rf_we", 64'(rf_we), 64'(e.we));
    chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
    chk("rf_wdata", rf_wdata, e.data);
    chk("rf_we_onehot", 64'(rf_we_onehot), 64'(e.oh));
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_addr = 5'd0; a_data = '0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = '0;

    // reset cycle
    @(posedge clk);
    #1;
    chk("rst_we", 64'(rf_we), 64'(1'b0));
    chk("rst_waddr", 64'(rf_waddr), 64'(5'd0));
    chk("rst_wdata", rf_wdata, 64'h0);
    chk("rst_onehot", 64'(rf_we_onehot), 64'(32'h0));
    chk("rst_busy", 64'(busy), 64'(1'b1));
    m_clear = 1'b1; m_cnt = 0; m_rr = 1'b0;
    m_we = 1'b0; m_waddr = 5'd0; m_wdata = '0;
    reset = 1'b0;

    // request held during the whole zero-fill sequence
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 31; i++) begin
      cycle();
      chk("clr_ready_held", 64'(obs_ar), 64'(1'b0));
      chk("clr_onehot", 64'(rf_we_onehot), 64'(32'h1 << i));
      chk("clr_wdata", rf_wdata, 64'h0);
    end
    chk("clr_done_busy", 64'(busy), 64'(1'b0));

    // first RUN cycle grants the held request with its data intact
    cycle();
    chk("held_grant", 64'(obs_ar), 64'(1'b1));
    chk("held_waddr", 64'(rf_waddr), 64'(5'd7));
    chk("held_wdata", rf_wdata, 64'h1234_5678_9ABC_DEF0);

    // A only, addr 5
    a_addr = 5'd5; a_data = 64'hDEAD;
    cycle();
    chk("a5_ready", 64'(obs_ar), 64'(1'b1));
    chk("a5_we", 64'(rf_we), 64'(1'b1));
    chk("a5_onehot", 64'(rf_we_onehot), 64'(32'h0000_0020));

    // idle: no write, address and data hold
    a_valid = 1'b0;
    cycle();
    chk("idle_we", 64'(rf_we), 64'(1'b0));
    chk("idle_waddr", 64'(rf_waddr), 64'(5'd5));
    chk("idle_wdata", rf_wdata, 64'hDEAD);

    // contested: grants A,B,A,B
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA0;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hB0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_a", 64'(obs_ar), 64'(i % 2 == 0));
      chk("rr_b", 64'(obs_br), 64'(i % 2 == 1));
      chk("rr_waddr", 64'(rf_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
      if (obs_ar) a_data = a_data + 64'd1;
      else        b_data = b_data + 64'd1;
    end

    // B to XZR: handshake completes, write suppressed
    a_valid = 1'b0;
    b_addr = 5'd31; b_data = 64'hFFFF;
    cycle();
    chk("xzr_ready", 64'(obs_br), 64'(1'b1));
    chk("xzr_we", 64'(rf_we), 64'(1'b0));
    chk("xzr_onehot", 64'(rf_we_onehot), 64'(32'h0));
    b_valid = 1'b0;

    // back-to-back writes
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_addr = 5'(10 + i); a_data = 64'(100 + i);
      cycle();
      chk("b2b_we", 64'(rf_we), 64'(1'b1));
      chk("b2b_waddr", 64'(rf_waddr), 64'(10 + i));
    end

    // accept and reset in the same cycle: write discarded, CLEAR restarts
    a_addr = 5'd9; a_data = 64'h99;
    reset = 1'b1;
    cycle();
    chk("rstrun_we", 64'(rf_we), 64'(1'b0));
    chk("rstrun_busy", 64'(busy), 64'(1'b1));
    reset = 1'b0; a_valid = 1'b0;
    cycle();
    chk("rstrun_clr0", 64'(rf_we_onehot), 64'(32'h1));
    for (int i = 0; i < 4; i++) cycle();

    // reset in the middle of CLEAR restarts at register 0
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rstclr_clr0", 64'(rf_we_onehot), 64'(32'h1));
    cycle();
    chk("rstclr_clr1", 64'(rf_we_onehot), 64'(32'h2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
